// File: rtl/tage_pkg.sv
// Shared TAGE predictor definitions: default history geometry and the
// history warm-up state encoding.
package tage_pkg;

    localparam int unsigned GHR_LEN_DEFAULT = 64;
    localparam int unsigned FOLD_W_DEFAULT  = 10;

    typedef enum logic {
        WARM = 1'b0,
        FULL = 1'b1
    } hist_state_e;

    // Bits needed to count 0..len inclusive
    function automatic int unsigned cnt_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/folded_history_fold_step.sv
// Incremental folded-history update: rotate left by one, inject the newest
// outcome at bit 0 and cancel the bit shifted out of the full history.
module fold_step
    import tage_pkg::*;
#(
    parameter int unsigned GHR_LEN = GHR_LEN_DEFAULT,
    parameter int unsigned FOLD_W  = FOLD_W_DEFAULT
) (
    input  logic [FOLD_W-1:0] fold_cur,
    input  logic              in_bit,
    input  logic              out_bit,
    output logic [FOLD_W-1:0] fold_next_c
);

    // The outgoing history bit lands here after the rotate
    localparam int unsigned OUT_POS = GHR_LEN % FOLD_W;

    always_comb begin
        fold_next_c          = {fold_cur[FOLD_W-2:0], fold_cur[FOLD_W-1]};
        fold_next_c[0]       = fold_next_c[0] ^ in_bit;
        fold_next_c[OUT_POS] = fold_next_c[OUT_POS] ^ out_bit;
    end

endmodule

// File: rtl/folded_history.sv
// Global branch history with incrementally folded copy, checkpoint restore,
// warm-up tracking and index hash. Optional fold self-check: FOLD_CHECK_EN.
module folded_history
    import tage_pkg::*;
#(
    parameter int unsigned GHR_LEN = GHR_LEN_DEFAULT,
    parameter int unsigned FOLD_W  = FOLD_W_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               upd_valid_i,
    input  logic               upd_taken_i,
    input  logic               restore_i,
    input  logic [GHR_LEN-1:0] restore_ghr_i,
    input  logic [FOLD_W-1:0]  restore_fold_i,
    input  logic [31:0]        pc_i,
    output logic [GHR_LEN-1:0] ghr_o,
    output logic [FOLD_W-1:0]  fold_o,
    output logic [FOLD_W-1:0]  idx_o,
    output logic               hist_valid_o,
    output logic               fold_err_o
);

    localparam int unsigned CNT_W = cnt_width(GHR_LEN);

    logic [GHR_LEN-1:0] ghr_q, ghr_d;
    logic [FOLD_W-1:0]  fold_q, fold_d, fold_step_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    hist_state_e        state_q, state_d;

    fold_step #(
        .GHR_LEN (GHR_LEN),
        .FOLD_W  (FOLD_W)
    ) u_fold_step (
        .fold_cur    (fold_q),
        .in_bit      (upd_taken_i),
        .out_bit     (ghr_q[GHR_LEN-1]),
        .fold_next_c (fold_step_c)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ghr_q   <= '0;
            fold_q  <= '0;
            cnt_q   <= '0;
            state_q <= WARM;
        end else begin
            ghr_q   <= ghr_d;
            fold_q  <= fold_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Restore wins over update and leaves warm-up tracking untouched
    always_comb begin
        ghr_d   = ghr_q;
        fold_d  = fold_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (restore_i) begin
            ghr_d  = restore_ghr_i;
            fold_d = restore_fold_i;
        end else if (upd_valid_i) begin
            ghr_d  = {ghr_q[GHR_LEN-2:0], upd_taken_i};
            fold_d = fold_step_c;
            if (cnt_q != CNT_W'(GHR_LEN)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Look at the next count so FULL shows the cycle after the filling update
        if (state_q == WARM && cnt_d == CNT_W'(GHR_LEN)) begin
            state_d = FULL;
        end
    end

    assign ghr_o        = ghr_q;
    assign fold_o       = fold_q;
    assign hist_valid_o = (state_q == FULL);
    assign idx_o        = pc_i[FOLD_W+1:2] ^ fold_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[31:FOLD_W+2], pc_i[1:0]};

`ifdef FOLD_CHECK_EN
    logic [FOLD_W-1:0] fold_ref_c;
    logic              err_q;

    // Direct fold of the full history, independent of the incremental path
    always_comb begin
        fold_ref_c = '0;
        for (int unsigned i = 0; i < GHR_LEN; i++) begin
            fold_ref_c[i % FOLD_W] = fold_ref_c[i % FOLD_W] ^ ghr_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (fold_ref_c != fold_q) begin
            err_q <= 1'b1;
        end
    end

    assign fold_err_o = err_q;
`else
    assign fold_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_folded_history.sv
// Directed and random checks of folded_history at GHR_LEN=64, FOLD_W=10.
module tb_folded_history;

    localparam int unsigned GL = 64;
    localparam int unsigned FW = 10;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          upd_valid_i;
    logic          upd_taken_i;
    logic          restore_i;
    logic [GL-1:0] restore_ghr_i;
    logic [FW-1:0] restore_fold_i;
    logic [31:0]   pc_i;
    logic [GL-1:0] ghr_o;
    logic [FW-1:0] fold_o;
    logic [FW-1:0] idx_o;
    logic          hist_valid_o;
    logic          fold_err_o;

    int unsigned pass_cnt = 0;
    int unsigned chk_cnt  = 0;

    folded_history #(.GHR_LEN(GL), .FOLD_W(FW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .upd_valid_i    (upd_valid_i),
        .upd_taken_i    (upd_taken_i),
        .restore_i      (restore_i),
        .restore_ghr_i  (restore_ghr_i),
        .restore_fold_i (restore_fold_i),
        .pc_i           (pc_i),
        .ghr_o          (ghr_o),
        .fold_o         (fold_o),
        .idx_o          (idx_o),
        .hist_valid_o   (hist_valid_o),
        .fold_err_o     (fold_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [FW-1:0] fold_of(input logic [GL-1:0] g);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < int'(GL); i++) f[i % FW] = f[i % FW] ^ g[i];
        return f;
    endfunction

    task automatic idle_inputs();
        upd_valid_i    = 1'b0;
        upd_taken_i    = 1'b0;
        restore_i      = 1'b0;
        restore_ghr_i  = '0;
        restore_fold_i = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic taken_updates(input int n);
        upd_valid_i = 1'b1;
        upd_taken_i = 1'b1;
        for (int k = 0; k < n; k++) tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if (ghr_o !== '0 || fold_o !== '0 || hist_valid_o !== 1'b0 || fold_err_o !== 1'b0)
            $display("FAIL reset_state: ghr=%h fold=%h hv=%b err=%b, want all 0", ghr_o, fold_o, hist_valid_o, fold_err_o);
        else pass_cnt++;
    endtask

    task automatic test_single_update();
        do_reset();
        taken_updates(1);
        chk_cnt++;
        if (ghr_o !== 64'h1 || fold_o !== 10'h001 || hist_valid_o !== 1'b0)
            $display("FAIL single_update: ghr=%h fold=%h hv=%b, want 1/001/0", ghr_o, fold_o, hist_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        logic [GL-1:0] g;
        logic [FW-1:0] f;
        // Start from the single-update state, then feed a not-taken update
        upd_valid_i = 1'b1;
        upd_taken_i = 1'b0;
        tick();
        idle_inputs();
        chk_cnt++;
        if (ghr_o !== 64'h2 || fold_o !== 10'h002)
            $display("FAIL not_taken_shift: ghr=%h fold=%h, want 2/002", ghr_o, fold_o);
        else pass_cnt++;
        g = ghr_o;
        f = fold_o;
        upd_taken_i = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        idle_inputs();
        chk_cnt++;
        if (ghr_o !== g || fold_o !== f)
            $display("FAIL hold_idle: ghr=%h fold=%h, want %h/%h", ghr_o, fold_o, g, f);
        else pass_cnt++;
    endtask

    task automatic test_warmup();
        do_reset();
        taken_updates(63);
        chk_cnt++;
        if (hist_valid_o !== 1'b0)
            $display("FAIL warm_63: hv=%b, want 0", hist_valid_o);
        else pass_cnt++;
        taken_updates(1);
        chk_cnt++;
        if (ghr_o !== {GL{1'b1}} || fold_o !== 10'h00F || hist_valid_o !== 1'b1)
            $display("FAIL warm_64: ghr=%h fold=%h hv=%b, want ones/00F/1", ghr_o, fold_o, hist_valid_o);
        else pass_cnt++;
        taken_updates(1);
        chk_cnt++;
        if (ghr_o !== {GL{1'b1}} || fold_o !== 10'h00F || hist_valid_o !== 1'b1)
            $display("FAIL warm_65: ghr=%h fold=%h hv=%b, want ones/00F/1", ghr_o, fold_o, hist_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_restore();
        do_reset();
        taken_updates(3);
        restore_i      = 1'b1;
        restore_ghr_i  = 64'h5;
        restore_fold_i = 10'h005;
        upd_valid_i    = 1'b1;
        upd_taken_i    = 1'b1;
        tick();
        idle_inputs();
        chk_cnt++;
        if (ghr_o !== 64'h5 || fold_o !== 10'h005 || hist_valid_o !== 1'b0)
            $display("FAIL restore_load: ghr=%h fold=%h hv=%b, want 5/005/0", ghr_o, fold_o, hist_valid_o);
        else pass_cnt++;
        // Counter held at 3: 60 more leaves it at 63, the 61st fills it
        taken_updates(60);
        chk_cnt++;
        if (hist_valid_o !== 1'b0)
            $display("FAIL restore_cnt_63: hv=%b, want 0", hist_valid_o);
        else pass_cnt++;
        taken_updates(1);
        chk_cnt++;
        if (hist_valid_o !== 1'b1)
            $display("FAIL restore_cnt_64: hv=%b, want 1", hist_valid_o);
        else pass_cnt++;
        // A restore while FULL must not drop back to WARM
        restore_i      = 1'b1;
        restore_ghr_i  = '0;
        restore_fold_i = '0;
        tick();
        idle_inputs();
        chk_cnt++;
        if (hist_valid_o !== 1'b1 || ghr_o !== '0 || fold_o !== '0)
            $display("FAIL restore_full: ghr=%h fold=%h hv=%b, want 0/000/1", ghr_o, fold_o, hist_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_idx();
        restore_i      = 1'b1;
        restore_ghr_i  = 64'h3FF;
        restore_fold_i = 10'h3FF;
        tick();
        idle_inputs();
        pc_i = 32'h0000_0FFC;
        #1;
        chk_cnt++;
        if (fold_o !== 10'h3FF || idx_o !== 10'h000)
            $display("FAIL idx_zero: fold=%h idx=%h, want 3FF/000", fold_o, idx_o);
        else pass_cnt++;
        pc_i = 32'h0000_0004;
        #1;
        chk_cnt++;
        if (idx_o !== 10'h3FE)
            $display("FAIL idx_comb: idx=%h, want 3FE", idx_o);
        else pass_cnt++;
        pc_i = 32'hFFFF_F003;
        #1;
        chk_cnt++;
        if (idx_o !== 10'h3FF)
            $display("FAIL idx_ignore_bits: idx=%h, want 3FF", idx_o);
        else pass_cnt++;
        pc_i = '0;
    endtask

    task automatic test_random();
        logic [GL-1:0] g_m;
        int            cnt_m;
        int            bad;
        do_reset();
        g_m   = '0;
        cnt_m = 0;
        bad   = 0;
        for (int k = 0; k < 10000; k++) begin
            restore_i   = ($urandom_range(0, 15) == 0);
            upd_valid_i = ($urandom_range(0, 3) != 0);
            upd_taken_i = $urandom_range(0, 1) == 1;
            restore_ghr_i  = {$urandom, $urandom};
            restore_fold_i = fold_of(restore_ghr_i);
            pc_i           = $urandom;
            if (restore_i) g_m = restore_ghr_i;
            else if (upd_valid_i) begin
                g_m = {g_m[GL-2:0], upd_taken_i};
                if (cnt_m < int'(GL)) cnt_m++;
            end
            tick();
            chk_cnt++;
            if (ghr_o !== g_m || fold_o !== fold_of(g_m) || hist_valid_o !== (cnt_m == int'(GL))
                || fold_err_o !== 1'b0 || idx_o !== (pc_i[FW+1:2] ^ fold_of(g_m))) begin
                if (bad < 10)
                    $display("FAIL random[%0d]: ghr=%h fold=%h hv=%b err=%b idx=%h, want %h/%h/%b/0",
                             k, ghr_o, fold_o, hist_valid_o, fold_err_o, idx_o, g_m, fold_of(g_m), cnt_m == int'(GL));
                bad++;
            end else pass_cnt++;
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        taken_updates(5);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_cnt++;
        if (ghr_o !== '0 || fold_o !== '0 || hist_valid_o !== 1'b0 || fold_err_o !== 1'b0)
            $display("FAIL async_reset: ghr=%h fold=%h hv=%b err=%b, want all 0", ghr_o, fold_o, hist_valid_o, fold_err_o);
        else pass_cnt++;
        tick();
        rst_ni = 1'b1;
        taken_updates(1);
        chk_cnt++;
        if (ghr_o !== 64'h1 || fold_o !== 10'h001 || hist_valid_o !== 1'b0)
            $display("FAIL post_reset_update: ghr=%h fold=%h hv=%b, want 1/001/0", ghr_o, fold_o, hist_valid_o);
        else pass_cnt++;
    endtask

    initial begin
        rst_ni = 1'b0;
        pc_i   = '0;
        idle_inputs();
        test_reset();
        test_single_update();
        test_hold();
        test_warmup();
        test_restore();
        test_idx();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/folded_history.md
FOLDED_HISTORY -- requirements
Module: folded_history

Interface
REQ-001 SHALL have parameter GHR_LEN, default 64: global history length in bits.
REQ-002 SHALL have parameter FOLD_W, default 10: folded history width; legal range 2..GHR_LEN-1.
REQ-003 SHALL have port clk_i  input  1: single clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port upd_valid_i  input  1: one resolved branch outcome this cycle.
REQ-006 SHALL have port upd_taken_i  input  1: outcome bit, 1 = taken.
REQ-007 SHALL have port restore_i  input  1: mispredict recovery; load checkpoint.
REQ-008 SHALL have port restore_ghr_i  input  GHR_LEN: checkpointed history.
REQ-009 SHALL have port restore_fold_i  input  FOLD_W: checkpointed folded value.
REQ-010 SHALL have port pc_i  input  32: fetch PC for index hashing.
REQ-011 SHALL have port ghr_o  output  GHR_LEN: registered history; bit 0 = newest.
REQ-012 SHALL have port fold_o  output  FOLD_W: registered folded history.
REQ-013 SHALL have port idx_o  output  FOLD_W: combinational pc_i[FOLD_W+1:2] XOR fold_o.
REQ-014 SHALL have port hist_valid_o  output  1: history fully populated since reset.
REQ-015 SHALL have port fold_err_o  output  1: sticky fold self-check error.

Function
REQ-016 SHALL, on upd_valid_i=1 and restore_i=0, set ghr_o next cycle to {ghr_o[GHR_LEN-2:0], upd_taken_i}.
REQ-017 SHALL, in the same cycle, set fold_o next cycle to rotate-left-by-1(fold_o), then bit 0 XOR upd_taken_i, then bit (GHR_LEN mod FOLD_W) XOR outgoing ghr_o[GHR_LEN-1].
REQ-018 SHALL hold the invariant: fold_o bit j = XOR of all ghr_o bits i where i mod FOLD_W = j.
REQ-019 SHALL give ghr_o and fold_o a latency of exactly one cycle from update; idx_o SHALL have zero latency from pc_i.
REQ-020 SHALL hold ghr_o and fold_o unchanged when upd_valid_i=0 and restore_i=0.
REQ-021 SHALL, on restore_i=1, load restore_ghr_i and restore_fold_i next cycle; restore has priority and discards a same-cycle update.
REQ-022 SHALL keep a warm-up counter, ceil(log2(GHR_LEN+1)) bits, incremented per accepted update and saturating at GHR_LEN.
REQ-023 SHALL run a two-state FSM: WARM -> FULL when the counter reaches GHR_LEN; hist_valid_o = (state == FULL), registered.
REQ-024 SHALL, on restore_i=1, leave the counter and FSM state unchanged; the FSM SHALL NOT return from FULL to WARM except on reset.

Reset
REQ-025 SHALL asynchronously clear ghr_o, fold_o, counter and fold_err_o to 0 and FSM to WARM (hist_valid_o=0) while rst_ni=0.
REQ-026 SHALL accept updates starting from the first rising edge after rst_ni deasserts; reset asserted mid-sequence SHALL discard all history.

Configuration
REQ-027 SHALL use macro FOLD_CHECK_EN: when defined, recompute the fold directly from ghr_o each cycle and set fold_err_o (sticky until reset) on any mismatch with fold_o.
REQ-028 SHALL, when FOLD_CHECK_EN is undefined, omit the checker logic and tie fold_err_o to 0.

Structure
REQ-029 SHALL take GHR_LEN and FOLD_W defaults and the FSM state enum (WARM, FULL) from shared package tage_pkg.
REQ-030 SHALL isolate the next-fold computation of REQ-017 in combinational sub-module fold_step, for reuse by the tag-fold instances.

Verification (GHR_LEN=64, FOLD_W=10, so GHR_LEN mod FOLD_W = 4)
REQ-031 SHALL cover: reset release -> ghr_o=0, fold_o=0x000, hist_valid_o=0, fold_err_o=0.
REQ-032 SHALL cover: one taken update -> next cycle ghr_o=0x1, fold_o=0x001, hist_valid_o=0.
REQ-033 SHALL cover: 64 consecutive taken updates -> ghr_o all ones, fold_o=0x00F, hist_valid_o=1 the cycle after the 64th; a 65th taken update -> fold_o stays 0x00F.
REQ-034 SHALL cover: restore_i=1 with restore_ghr_i=0x5, restore_fold_i=0x005 and a same-cycle taken update -> next cycle ghr_o=0x5, fold_o=0x005, counter unchanged.
REQ-035 SHALL cover: fold_o=0x3FF, pc_i=0x0000_0FFC -> idx_o=0x000; idx_o SHALL change in the same cycle pc_i changes.
REQ-036 SHALL cover: 10k random updates/restores with consistent checkpoints and FOLD_CHECK_EN defined -> fold_err_o stays 0; rst_ni pulsed mid-run -> all outputs 0 asynchronously.
